fifo64_unpack: RTL and testbench

- Read-side consumer for the 64-bit peripheral FIFO.
- Pops 64-bit words from the FIFO's read port and emits them as OUT_WIDTH-bit slices on a valid/ready stream, e.g. into a byte-wide UART TX or a 16/32-bit bus master.
- Hides the FIFO's one-cycle registered read latency and guarantees the FIFO is never read while empty.

---
 rtl/fifo64_unpack_if.sv | 49 ++++
 rtl/fifo64_unpack.sv | 108 ++++++++++
 tb/tb_fifo64_unpack.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo64_unpack_if.sv
// fifo64_unpack_if
// Bundles the FIFO read port and the downstream valid/ready slice stream of fifo64_unpack.
//   master : the unpacker's view (drives o_*, samples i_*)
//   slave  : the environment's view (FIFO plus downstream consumer)
// Signals:
//   i_fifo_empty  FIFO empty flag
//   o_fifo_read   FIFO read strobe, one pulse pops one word
//   i_fifo_rdata  FIFO read data, valid the cycle after o_fifo_read
//   o_valid       slice available on o_data
//   i_ready       downstream accepts the slice
//   o_data        current OUT_WIDTH-bit slice
//   o_last        current slice is the final slice of its word
//   o_busy        unpacker holds or is fetching a word
interface fifo64_unpack_if #(
  parameter int unsigned OUT_WIDTH = 16
) ();

  logic                 i_fifo_empty;
  logic                 o_fifo_read;
  logic [63:0]          i_fifo_rdata;
  logic                 o_valid;
  logic                 i_ready;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_last;
  logic                 o_busy;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_rdata,
    input  i_ready,
    output o_fifo_read,
    output o_valid,
    output o_data,
    output o_last,
    output o_busy
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_rdata,
    output i_ready,
    input  o_fifo_read,
    input  o_valid,
    input  o_data,
    input  o_last,
    input  o_busy
  );

endinterface

// File: rtl/fifo64_unpack.sv
// fifo64_unpack
// Read-side consumer for the 64-bit peripheral FIFO. Pops one 64-bit word at a time and emits
// it as 64/OUT_WIDTH slices on a valid/ready stream, hiding the FIFO's one-cycle registered
// read latency and never reading the FIFO while it is empty.
// Parameters:
//   OUT_WIDTH  slice width: 8, 16, 32 or 64 (must match the interface instance)
//   LSB_FIRST  1: slice 0 is bits [OUT_WIDTH-1:0]; 0: slice 0 is bits [63:64-OUT_WIDTH]
// Ports:
//   i_clock    sole clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        fifo64_unpack_if master modport (FIFO read port + slice stream)
module fifo64_unpack #(
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  fifo64_unpack_if.master bus
);

  localparam int unsigned N = 64 / OUT_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  if (!((OUT_WIDTH == 8) || (OUT_WIDTH == 16) || (OUT_WIDTH == 32) || (OUT_WIDTH == 64)))
  begin : g_bad_width
    $error("fifo64_unpack: OUT_WIDTH must be 8, 16, 32 or 64");
  end

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StEmit
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [63:0]     word_q, word_d;

  logic            emit;
  logic            last;
  logic            hs;
  logic            rd;
  logic [IdxW-1:0] sel;
  logic [5:0]      shamt;
  logic [63:0]     shifted;

  always_comb begin
    emit = (state_q == StEmit);
    last = emit && (idx_q == LastIdx);
    hs   = emit && bus.i_ready;
    // The FIFO advances its pointer even when empty, so the empty flag gates every read.
    // Reset also gates it so nothing is popped while the block is held in reset.
    rd   = i_reset_n && !bus.i_fifo_empty && ((state_q == StIdle) || (hs && last));
  end

  // Slice select: MSB-first order simply walks the word from the top slice down.
  always_comb begin
    sel     = LSB_FIRST ? idx_q : (LastIdx - idx_q);
    shamt   = 6'(sel) * 6'(OUT_WIDTH);
    shifted = word_q >> shamt;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (rd) state_d = StLoad;
      end
      StLoad: begin
        // Read data is valid exactly one cycle after the strobe.
        word_d  = bus.i_fifo_rdata;
        idx_d   = '0;
        state_d = StEmit;
      end
      StEmit: begin
        if (hs) begin
          if (!last)   idx_d   = idx_q + 1'b1;
          else if (rd) state_d = StLoad;
          else         state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign bus.o_fifo_read = rd;
  assign bus.o_valid     = emit;
  assign bus.o_last      = last;
  assign bus.o_busy      = (state_q != StIdle);
  // Data is forced to zero outside EMIT so stale words never leak onto the stream.
  assign bus.o_data      = emit ? shifted[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fifo64_unpack.sv
module tb_fifo64_unpack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo64_unpack_if #(.OUT_WIDTH(16)) b16l ();
  fifo64_unpack_if #(.OUT_WIDTH(16)) b16m ();
  fifo64_unpack_if #(.OUT_WIDTH(8))  b8 ();
  fifo64_unpack_if #(.OUT_WIDTH(64)) b64 ();

  fifo64_unpack #(.OUT_WIDTH(16), .LSB_FIRST(1'b1)) u_16l (
    .i_clock(clk), .i_reset_n(rst_n), .bus(b16l.master));
  fifo64_unpack #(.OUT_WIDTH(16), .LSB_FIRST(1'b0)) u_16m (
    .i_clock(clk), .i_reset_n(rst_n), .bus(b16m.master));
  fifo64_unpack #(.OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_8 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(b8.master));
  fifo64_unpack #(.OUT_WIDTH(64), .LSB_FIRST(1'b1)) u_64 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(b64.master));

  // Behavioural FIFOs: registered read data, registered empty flag, pop-while-empty counted.
  logic [63:0] q_16l[$], q_16m[$], q_8[$], q_64[$];
  logic        push_16l = 0, push_16m = 0, push_8 = 0, push_64 = 0;
  logic [63:0] pd_16l = 0, pd_16m = 0, pd_8 = 0, pd_64 = 0;
  logic [63:0] rdat_16l = 0, rdat_16m = 0, rdat_8 = 0, rdat_64 = 0;
  logic        emp_16l = 1, emp_16m = 1, emp_8 = 1, emp_64 = 1;
  logic        rdy_16l = 0, rdy_16m = 0, rdy_8 = 0, rdy_64 = 0;
  int          rde_16l = 0, rde_16m = 0, rde_8 = 0, rde_64 = 0;

  assign b16l.i_fifo_empty = emp_16l; assign b16l.i_fifo_rdata = rdat_16l;
  assign b16l.i_ready = rdy_16l;
  assign b16m.i_fifo_empty = emp_16m; assign b16m.i_fifo_rdata = rdat_16m;
  assign b16m.i_ready = rdy_16m;
  assign b8.i_fifo_empty = emp_8;     assign b8.i_fifo_rdata = rdat_8;
  assign b8.i_ready = rdy_8;
  assign b64.i_fifo_empty = emp_64;   assign b64.i_fifo_rdata = rdat_64;
  assign b64.i_ready = rdy_64;

  always @(posedge clk) begin
    if (b16l.o_fifo_read) begin
      if (q_16l.size() == 0) rde_16l <= rde_16l + 1;
      else rdat_16l <= q_16l.pop_front();
    end
    if (push_16l) q_16l.push_back(pd_16l);
    emp_16l <= (q_16l.size() == 0);
  end

  always @(posedge clk) begin
    if (b16m.o_fifo_read) begin
      if (q_16m.size() == 0) rde_16m <= rde_16m + 1;
      else rdat_16m <= q_16m.pop_front();
    end
    if (push_16m) q_16m.push_back(pd_16m);
    emp_16m <= (q_16m.size() == 0);
  end

  always @(posedge clk) begin
    if (b8.o_fifo_read) begin
      if (q_8.size() == 0) rde_8 <= rde_8 + 1;
      else rdat_8 <= q_8.pop_front();
    end
    if (push_8) q_8.push_back(pd_8);
    emp_8 <= (q_8.size() == 0);
  end

  always @(posedge clk) begin
    if (b64.o_fifo_read) begin
      if (q_64.size() == 0) rde_64 <= rde_64 + 1;
      else rdat_64 <= q_64.pop_front();
    end
    if (push_64) q_64.push_back(pd_64);
    emp_64 <= (q_64.size() == 0);
  end

  // Reference slice i of word w for a given width and ordering.
  function automatic logic [63:0] ref_slice(input logic [63:0] w, input int width,
                                            input bit lsb, input int i);
    int          n;
    int          pos;
    logic [63:0] m;
    n   = 64 / width;
    pos = lsb ? i : (n - 1 - i);
    m   = (width == 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (w >> (pos * width)) & m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({b16l.o_fifo_read, b16l.o_valid, b16l.o_last, b16l.o_busy} !== 4'b0 ||
        b16l.o_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rd/v/l/b=%b data=%h expected 0000 0000",
               {b16l.o_fifo_read, b16l.o_valid, b16l.o_last, b16l.o_busy}, b16l.o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if ({b16l.o_fifo_read, b16l.o_valid, b16l.o_busy} !== 3'b0 || b16l.o_data !== 16'h0) begin
        errors++;
        $display("FAIL idle_empty16 c=%0d: got rd/v/b=%b data=%h expected 000 0000", c,
                 {b16l.o_fifo_read, b16l.o_valid, b16l.o_busy}, b16l.o_data);
      end
      checks++;
      if ({b8.o_fifo_read, b8.o_busy, b64.o_fifo_read, b64.o_busy} !== 4'b0) begin
        errors++;
        $display("FAIL idle_empty8_64 c=%0d: got %b expected 0000", c,
                 {b8.o_fifo_read, b8.o_busy, b64.o_fifo_read, b64.o_busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lsb16();
    logic [63:0] w;
    int          t_rd;
    int          k;
    int          nrd;
    w = 64'h0123_4567_89AB_CDEF;
    t_rd = -1; k = 0; nrd = 0;
    rdy_16l = 1'b1;
    push_16l = 1'b1; pd_16l = w;
    @(negedge clk);
    push_16l = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (b16l.o_fifo_read) begin
        nrd++;
        if (t_rd < 0) t_rd = cyc;
      end
      if (b16l.o_valid) begin
        if (k == 0) begin
          checks++;
          if (cyc !== t_rd + 2) begin
            errors++;
            $display("FAIL lsb16_latency: got cycle %0d expected %0d", cyc, t_rd + 2);
          end
        end
        checks++;
        if (k > 3 || 64'(b16l.o_data) !== ref_slice(w, 16, 1'b1, k) ||
            b16l.o_last !== (k == 3)) begin
          errors++;
          $display("FAIL lsb16_slice%0d: got data=%h last=%b expected %h last=%b", k,
                   b16l.o_data, b16l.o_last, ref_slice(w, 16, 1'b1, k), (k == 3));
        end
        k++;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (k !== 4 || nrd !== 1 || b16l.o_busy !== 1'b0 || rde_16l !== 0) begin
      errors++;
      $display("FAIL lsb16_totals: got slices=%0d reads=%0d busy=%b rde=%0d expected 4 1 0 0",
               k, nrd, b16l.o_busy, rde_16l);
    end
    rdy_16l = 1'b0;
  endtask

  task automatic test_msb16_stall();
    logic [63:0] w;
    int          k;
    bit          stalled;
    w = 64'h0123_4567_89AB_CDEF;
    k = 0; stalled = 0;
    push_16m = 1'b1; pd_16m = w;
    @(negedge clk);
    push_16m = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rdy_16m = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      if (b16m.o_valid) begin
        checks++;
        if (k > 3 || 64'(b16m.o_data) !== ref_slice(w, 16, 1'b0, k) ||
            b16m.o_last !== (k == 3)) begin
          errors++;
          $display("FAIL msb16_slice%0d stall=%0d: got data=%h last=%b expected %h last=%b",
                   k, stalled, b16m.o_data, b16m.o_last, ref_slice(w, 16, 1'b0, k), (k == 3));
        end
        if (rdy_16m) begin
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
        end
      end else if (stalled) begin
        checks++;
        errors++;
        $display("FAIL msb16_valid_drop: got valid=0 expected 1 while slice %0d pending", k);
        stalled = 0;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (k !== 4 || b16m.o_busy !== 1'b0 || rde_16m !== 0) begin
      errors++;
      $display("FAIL msb16_totals: got slices=%0d busy=%b rde=%0d expected 4 0 0",
               k, b16m.o_busy, rde_16m);
    end
    rdy_16m = 1'b0;
  endtask

  task automatic test_stream8();
    logic [63:0] words[3];
    int          k;
    int          nrd;
    int          first_v;
    int          last_hs;
    k = 0; nrd = 0; first_v = -1; last_hs = -1;
    for (int i = 0; i < 3; i++) words[i] = {$urandom, $urandom};
    rdy_8 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      push_8 = (c < 3);
      pd_8   = (c < 3) ? words[c] : 64'h0;
      #1;
      if (b8.o_fifo_read) begin
        nrd++;
        checks++;
        if (!(!b8.o_busy || (b8.o_valid && b8.o_last && rdy_8))) begin
          errors++;
          $display("FAIL stream8_read_point: got busy=%b valid=%b last=%b expected idle or final hs",
                   b8.o_busy, b8.o_valid, b8.o_last);
        end
      end
      if (b8.o_valid) begin
        if (first_v < 0) first_v = cyc;
        checks++;
        if (k > 23 || 64'(b8.o_data) !== ref_slice(words[(k / 8) % 3], 8, 1'b1, k % 8) ||
            b8.o_last !== ((k % 8) == 7)) begin
          errors++;
          $display("FAIL stream8_slice%0d: got data=%h last=%b expected %h last=%b", k,
                   b8.o_data, b8.o_last, ref_slice(words[(k / 8) % 3], 8, 1'b1, k % 8),
                   ((k % 8) == 7));
        end
        if (k == 23) last_hs = cyc;
        k++;
      end
      @(negedge clk);
    end
    push_8 = 1'b0;
    checks++;
    if (k !== 24 || nrd !== 3 || (last_hs - first_v) !== 25 || rde_8 !== 0) begin
      errors++;
      $display("FAIL stream8_totals: got slices=%0d reads=%0d span=%0d rde=%0d expected 24 3 25 0",
               k, nrd, last_hs - first_v, rde_8);
    end
    rdy_8 = 1'b0;
  endtask

  task automatic test_w64();
    int k;
    int nrd;
    k = 0; nrd = 0;
    rdy_64 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      push_64 = (c < 10);
      pd_64   = 64'(c);
      #1;
      if (b64.o_fifo_read) nrd++;
      @(negedge clk);
    end
    push_64 = 1'b0;
    #1;
    checks++;
    if (nrd !== 1 || b64.o_valid !== 1'b1 || b64.o_data !== 64'd0 || b64.o_last !== 1'b1) begin
      errors++;
      $display("FAIL w64_stalled: got reads=%0d valid=%b data=%h last=%b expected 1 1 0 1",
               nrd, b64.o_valid, b64.o_data, b64.o_last);
    end
    @(negedge clk);
    for (int c = 0; c < 120; c++) begin
      rdy_64 = 1'($urandom_range(0, 1));
      #1;
      if (b64.o_fifo_read) begin
        nrd++;
        checks++;
        if (!(!b64.o_busy || (b64.o_valid && rdy_64))) begin
          errors++;
          $display("FAIL w64_early_read: got busy=%b valid=%b ready=%b expected idle or hs",
                   b64.o_busy, b64.o_valid, rdy_64);
        end
      end
      if (b64.o_valid) begin
        checks++;
        if (b64.o_last !== 1'b1) begin
          errors++;
          $display("FAIL w64_last: got %b expected 1", b64.o_last);
        end
        if (rdy_64) begin
          checks++;
          if (b64.o_data !== 64'(k)) begin
            errors++;
            $display("FAIL w64_order: got %h expected %h", b64.o_data, 64'(k));
          end
          k++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (k !== 10 || nrd !== 10 || rde_64 !== 0) begin
      errors++;
      $display("FAIL w64_totals: got words=%0d reads=%0d rde=%0d expected 10 10 0", k, nrd, rde_64);
    end
    rdy_64 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] w1;
    logic [63:0] w2;
    int          k;
    int          nrd;
    w1 = {$urandom, $urandom};
    w2 = 64'hFFFF_0000_FFFF_0000;
    k = 0; nrd = 0;
    push_16l = 1'b1; pd_16l = w1;
    @(negedge clk);
    push_16l = 1'b0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      rdy_16l = 1'b1;
      #1;
      if (b16l.o_valid) k++;
      @(negedge clk);
    end
    rdy_16l = 1'b0;
    #1;
    checks++;
    if (k !== 2 || b16l.o_valid !== 1'b1 || 64'(b16l.o_data) !== ref_slice(w1, 16, 1'b1, 2)) begin
      errors++;
      $display("FAIL mid_index2: got hs=%0d valid=%b data=%h expected 2 1 %h", k, b16l.o_valid,
               b16l.o_data, ref_slice(w1, 16, 1'b1, 2));
    end
    @(negedge clk);
    push_16l = 1'b1; pd_16l = w2;
    @(negedge clk);
    push_16l = 1'b0;
    #1;
    checks++;
    if (b16l.o_fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_read: got %b expected 0", b16l.o_fifo_read);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b16l.o_fifo_read, b16l.o_valid, b16l.o_last, b16l.o_busy} !== 4'b0 ||
        b16l.o_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rd/v/l/b=%b data=%h expected 0000 0000",
               {b16l.o_fifo_read, b16l.o_valid, b16l.o_last, b16l.o_busy}, b16l.o_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (b16l.o_fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL reset_read c=%0d: got %b expected 0", c, b16l.o_fifo_read);
      end
    end
    checks++;
    if (q_16l.size() !== 1) begin
      errors++;
      $display("FAIL reset_fifo_level: got %0d expected 1", q_16l.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy_16l = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (b16l.o_fifo_read) nrd++;
      if (b16l.o_valid) begin
        checks++;
        if (k > 3 || 64'(b16l.o_data) !== ref_slice(w2, 16, 1'b1, k) ||
            b16l.o_last !== (k == 3)) begin
          errors++;
          $display("FAIL restart_slice%0d: got data=%h last=%b expected %h last=%b", k,
                   b16l.o_data, b16l.o_last, ref_slice(w2, 16, 1'b1, k), (k == 3));
        end
        k++;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (k !== 4 || nrd !== 1 || q_16l.size() !== 0 || b16l.o_busy !== 1'b0 || rde_16l !== 0) begin
      errors++;
      $display("FAIL restart_totals: got slices=%0d reads=%0d level=%0d busy=%b rde=%0d expected 4 1 0 0 0",
               k, nrd, q_16l.size(), b16l.o_busy, rde_16l);
    end
    rdy_16l = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb16();
    test_msb16_stall();
    test_stream8();
    test_w64();
    @(negedge clk);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
